gabor_window_gen_5x5: RTL and testbench
=======================================

// Module: gabor_window_gen_5x5
// PURPOSE
// - Streaming 5x5 sliding-window generator feeding the Gabor convolution blocks (0/45/90/135 deg).
// - Accepts a raster-order binary pixel stream and emits one 25-tap window per valid centre
//   position, pixel1..pixel25 row-major, ready for direct connection to the conv block pixel inputs.
// - Valid-only windows (no border padding): (IMG_HEIGHT-4)*(IMG_WIDTH-4) windows per frame.
// PARAMETERS
// - IMG_WIDTH   64  pixels per line; >=5
// - IMG_HEIGHT  64  lines per frame; >=5
// - PIXEL_W     1   bits per pixel; must match conv block pixel_int_width+pixel_dec_width
// PORTS
// - clk       in   1                  single clock, all logic rising-edge
// - rst_n     in   1                  asynchronous, active-low reset
// - s_valid   in   1                  input pixel valid
// - s_ready   out  1                  input pixel accepted when s_valid & s_ready
// - s_sof     in   1                  qualifies s_pixel as frame position (0,0)
// - s_pixel   in   PIXEL_W            raster-order pixel
// - m_valid   out  1                  window valid
// - m_ready   in   1                  window consumed when m_valid & m_ready
// - m_window  out  25*PIXEL_W         tap k (pixel k+1) at [k*PIXEL_W +: PIXEL_W]; k=0 top-left, k=24 bottom-right
// - m_row     out  $clog2(IMG_HEIGHT) window centre row
// - m_col     out  $clog2(IMG_WIDTH)  window centre column
// - m_eof     out  1                  set with the last window of a frame, centre (IMG_HEIGHT-3, IMG_WIDTH-3)
// BEHAVIOUR
// - Reset: m_valid=0, m_window=0, m_row=0, m_col=0, m_eof=0, row/col counters=0, window regs=0; line-buffer RAM not reset.
// - s_ready = !m_valid | m_ready (single output stage; full throughput, one pixel/cycle).
// - Accept at counter position (r,c): line buffer L0..L3 read at c (rows r-1..r-4), new pixel written to L0,
//   L_i output written to L_i+1 (read-before-write, same address); 5-tap column shifted into 5x5 window reg.
// - If r>=4 and c>=4: next cycle m_valid=1, m_window = rows r-4..r, cols c-4..c; m_row=r-2, m_col=c-2. Latency 1 cycle.
// - Accept with no new window and m_ready: m_valid falls to 0. m_valid/m_window/m_row/m_col/m_eof stable while m_valid & !m_ready.
// - Counters: c wraps IMG_WIDTH-1 -> 0 with r++; at (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0.
// - Columns 0..3 of each line only prime the window shift reg; no window ever spans two lines.
// - s_sof accepted: that pixel is (0,0) regardless of counters; mid-frame sof abandons frame silently;
//   an already-pending m_valid is still delivered. Stale line-buffer data never reaches an output (r>=4 gate).
// - s_sof on a pixel the counters already place at (0,0): no effect.
// - Async reset mid-frame: outputs drop to reset values immediately; pending window discarded.
// - Pixels are passed bit-exact; no arithmetic on data.
// STRUCTURE
// - Package gabor_win_pkg: KERNEL_SIZE=5, KERNEL_TAPS=25, LB_COUNT=4, function tap_idx(row,col)=row*5+col.
// - Sub-module gabor_line_buffer #(DEPTH, PIXEL_W): single-port-style RAM, synchronous read-before-write,
//   addr/we/din/dout; 4 instances chained. Top holds counters, 5x5 window regs, output stage.
// TESTING (IMG_WIDTH=8, IMG_HEIGHT=8 unless noted)
// - Reset, no stimulus -> m_valid=0, s_ready=1, m_window=0.
// - Frame with single 1 at (2,2), m_ready=1 -> first window after pixel (4,4), m_row=2, m_col=2, m_window=25'h0001000;
//   exactly 16 windows, m_eof only on window (5,5).
// - Random frame vs golden model, random m_ready (50%) -> every window matches model, none lost/duplicated; s_ready low
//   exactly when m_valid & !m_ready; outputs stable while stalled.
// - Frame of column index parity (pixel=c[0]) -> every window = 25'b10101_10101_... pattern matching c-4 parity; 4 windows per line, none with m_col<2.
// - s_sof asserted at 20th pixel -> no m_valid until 36 further pixels accepted; next window centre (2,2).
// - rst_n low for 1 cycle while m_valid=1 & m_ready=0 -> m_valid=0 asynchronously; next frame from (0,0) fully correct.

Source files
------------

// File: rtl/gabor_win_pkg.sv
// Shared constants and tap indexing for the 5x5 Gabor window generator.
package gabor_win_pkg;

    localparam int unsigned KERNEL_SIZE = 5;
    localparam int unsigned KERNEL_TAPS = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned LB_COUNT    = KERNEL_SIZE - 1;

    function automatic int unsigned tap_idx(input int unsigned row, input int unsigned col);
        return row * KERNEL_SIZE + col;
    endfunction

endpackage

// File: rtl/gabor_line_buffer.sv
// One image line of pixel storage; returns the previous line's pixel at addr while
// the current line's pixel is written to the same address.
module gabor_line_buffer #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned PIXEL_W = 1
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     we,
    input  logic [PIXEL_W-1:0]       din,
    output logic [PIXEL_W-1:0]       dout
);

    logic [PIXEL_W-1:0] mem [DEPTH];

    // Read is combinational so the column is usable in the accepting cycle; the write
    // only lands at the clock edge, so dout always shows the pre-write contents.
    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/gabor_window_gen_5x5.sv
// Streaming raster-to-5x5-window generator: four chained line buffers build a 5-tap
// column per pixel, which is shifted into a 5x5 window register and presented downstream.
module gabor_window_gen_5x5
    import gabor_win_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64,
    parameter int unsigned PIXEL_W    = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic                              s_sof,
    input  logic [PIXEL_W-1:0]                s_pixel,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [KERNEL_TAPS*PIXEL_W-1:0]    m_window,
    output logic [$clog2(IMG_HEIGHT)-1:0]     m_row,
    output logic [$clog2(IMG_WIDTH)-1:0]      m_col,
    output logic                              m_eof
);

    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam int unsigned CW = $clog2(IMG_WIDTH);

    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_FIRST  = RW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] COL_FIRST  = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_CENTRE = RW'(KERNEL_SIZE / 2);
    localparam logic [CW-1:0] COL_CENTRE = CW'(KERNEL_SIZE / 2);

    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] pos_row;
    logic [CW-1:0] pos_col;
    logic          accept;
    logic          win_now;

    logic [LB_COUNT-1:0][PIXEL_W-1:0]                     lb_din;
    logic [LB_COUNT-1:0][PIXEL_W-1:0]                     lb_dout;
    logic [KERNEL_SIZE-1:0][PIXEL_W-1:0]                  col_tap;
    logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PIXEL_W-1:0] win_q;
    logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PIXEL_W-1:0] win_d;
    logic [KERNEL_TAPS*PIXEL_W-1:0]                       win_flat;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

    // A start-of-frame pixel is placed at (0,0) whatever the counters say.
    always_comb begin
        pos_row = s_sof ? '0 : row_q;
        pos_col = s_sof ? '0 : col_q;
        win_now = accept && (pos_row >= ROW_FIRST) && (pos_col >= COL_FIRST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            if (pos_col == COL_LAST) begin
                col_q <= '0;
                row_q <= (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
            end else begin
                col_q <= pos_col + CW'(1);
                row_q <= pos_row;
            end
        end
    end

    for (genvar i = 0; i < LB_COUNT; i++) begin : g_lb
        gabor_line_buffer #(
            .DEPTH   (IMG_WIDTH),
            .PIXEL_W (PIXEL_W)
        ) u_lb (
            .clk  (clk),
            .addr (pos_col),
            .we   (accept),
            .din  (lb_din[i]),
            .dout (lb_dout[i])
        );
    end

    // L0 holds line r-1 and each stage pushes its old pixel one line further up.
    always_comb begin
        lb_din[0]               = s_pixel;
        col_tap                 = '0;
        col_tap[KERNEL_SIZE-1]  = s_pixel;
        for (int unsigned i = 1; i < LB_COUNT; i++) begin
            lb_din[i] = lb_dout[i-1];
        end
        for (int unsigned i = 0; i < LB_COUNT; i++) begin
            col_tap[LB_COUNT-1-i] = lb_dout[i];
        end
    end

    always_comb begin
        win_d    = win_q;
        win_flat = '0;
        for (int unsigned i = 0; i < KERNEL_SIZE; i++) begin
            for (int unsigned j = 0; j < KERNEL_SIZE; j++) begin
                if (j < KERNEL_SIZE - 1) begin
                    win_d[i][j] = win_q[i][j+1];
                end else begin
                    win_d[i][j] = col_tap[i];
                end
                win_flat[tap_idx(i, j)*PIXEL_W +: PIXEL_W] = win_d[i][j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else if (accept) begin
            win_q <= win_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_window <= '0;
            m_row    <= '0;
            m_col    <= '0;
            m_eof    <= 1'b0;
        end else if (win_now) begin
            m_valid  <= 1'b1;
            m_window <= win_flat;
            m_row    <= pos_row - ROW_CENTRE;
            m_col    <= pos_col - COL_CENTRE;
            m_eof    <= (pos_row == ROW_LAST) && (pos_col == COL_LAST);
        end else if (m_ready) begin
            m_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gabor_window_gen_5x5.sv
// Directed and randomized checks of gabor_window_gen_5x5 (8x8 frames) against an image-array reference model.
module tb_gabor_window_gen_5x5;

    localparam int W = 8;
    localparam int H = 8;

    typedef struct {
        logic [24:0] win;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        eof;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_ready, s_sof, m_valid, m_ready, m_eof;
    logic [0:0]  s_pixel;
    logic [24:0] m_window;
    logic [2:0]  m_row, m_col;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic img [H][W];
    int   mr = 0, mc = 0;
    int   win_count, eof_count;
    logic sof_track = 1'b0;
    int   acc_since_sof = 0;
    logic first_seen;
    logic [24:0] first_win;
    logic [2:0]  first_row, first_col;
    logic        stall_pending = 1'b0;
    logic [24:0] snap_win;
    logic [2:0]  snap_row, snap_col;
    logic        snap_eof;

    gabor_window_gen_5x5 #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .PIXEL_W    (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_sof    (s_sof),
        .s_pixel  (s_pixel),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_window (m_window),
        .m_row    (m_row),
        .m_col    (m_col),
        .m_eof    (m_eof)
    );

    always #5 clk = ~clk;

    function automatic logic pick(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic model_accept(input logic sof, input logic pix);
        exp_t e;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        if (sof_track) begin
            if (sof) acc_since_sof = 0;
            else     acc_since_sof++;
        end
        img[mr][mc] = pix;
        if (mr >= 4 && mc >= 4) begin
            e.win = '0;
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    e.win[i*5+j] = img[mr-4+i][mc-4+j];
            e.row = 3'(mr - 2);
            e.col = 3'(mc - 2);
            e.eof = (mr == H-1) && (mc == W-1);
            exp_q.push_back(e);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end
    endtask

    // Called at a falling edge; drives inputs, checks outputs, then advances one clock.
    task automatic do_cycle(input logic v, input logic sof, input logic pix, input logic rdy,
                            output logic accepted);
        exp_t e;
        s_valid = v; s_sof = sof; s_pixel = pix; m_ready = rdy;
        #1;
        if (stall_pending) begin
            checks++;
            assert (m_valid === 1'b1 && m_window === snap_win && m_row === snap_row &&
                    m_col === snap_col && m_eof === snap_eof)
            else begin
                failures++;
                $error("FAIL stall_stable observed v=%b w=%h r=%0d c=%0d e=%b expected v=1 w=%h r=%0d c=%0d e=%b",
                       m_valid, m_window, m_row, m_col, m_eof, snap_win, snap_row, snap_col, snap_eof);
            end
        end
        checks++;
        assert (s_ready === (!m_valid || m_ready))
        else begin
            failures++;
            $error("FAIL s_ready observed=%b expected=%b", s_ready, (!m_valid || m_ready));
        end
        if (sof_track && m_valid === 1'b1) begin
            checks++;
            assert (acc_since_sof == 36)
            else begin
                failures++;
                $error("FAIL sof_latency observed=%0d expected=36", acc_since_sof);
            end
            sof_track = 1'b0;
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0)
            else begin
                failures++;
                $error("FAIL extra_window observed row=%0d col=%0d expected=none", m_row, m_col);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (m_window === e.win)
                else begin failures++; $error("FAIL window observed=%h expected=%h", m_window, e.win); end
                checks++;
                assert (m_row === e.row)
                else begin failures++; $error("FAIL row observed=%0d expected=%0d", m_row, e.row); end
                checks++;
                assert (m_col === e.col)
                else begin failures++; $error("FAIL col observed=%0d expected=%0d", m_col, e.col); end
                checks++;
                assert (m_eof === e.eof)
                else begin failures++; $error("FAIL eof observed=%b expected=%b", m_eof, e.eof); end
            end
            win_count++;
            if (m_eof) eof_count++;
            if (!first_seen) begin
                first_seen = 1'b1;
                first_win  = m_window;
                first_row  = m_row;
                first_col  = m_col;
            end
        end
        stall_pending = (m_valid === 1'b1) && !m_ready;
        snap_win = m_window; snap_row = m_row; snap_col = m_col; snap_eof = m_eof;
        accepted = v && s_ready;
        @(posedge clk);
        if (accepted) model_accept(sof, pix);
        @(negedge clk);
    endtask

    task automatic send_pixel(input logic sof, input logic pix, input int mode);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 64) begin
            do_cycle(1'b1, sof, pix, pick(mode), acc);
            n++;
        end
        checks++;
        assert (acc)
        else begin failures++; $error("FAIL accept_timeout observed=0 expected=1"); end
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            do_cycle(1'b0, 1'b0, 1'b0, 1'b1, acc);
            n++;
        end
        do_cycle(1'b0, 1'b0, 1'b0, 1'b1, acc);
        checks++;
        assert (exp_q.size() == 0)
        else begin failures++; $error("FAIL lost_windows observed_pending=%0d expected=0", exp_q.size()); end
    endtask

    task automatic start_section();
        win_count = 0;
        eof_count = 0;
        first_seen = 1'b0;
    endtask

    initial begin
        logic acc;
        rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_pixel = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        checks++;
        assert (m_valid === 1'b0) else begin failures++; $error("FAIL rst_m_valid observed=%b expected=0", m_valid); end
        checks++;
        assert (s_ready === 1'b1) else begin failures++; $error("FAIL rst_s_ready observed=%b expected=1", s_ready); end
        checks++;
        assert (m_window === 25'h0 && m_row === 3'd0 && m_col === 3'd0 && m_eof === 1'b0)
        else begin failures++; $error("FAIL rst_outputs observed w=%h r=%0d c=%0d e=%b expected all 0", m_window, m_row, m_col, m_eof); end
        rst_n = 1'b1;
        @(negedge clk);

        // Single set pixel at (2,2)
        start_section();
        for (int p = 0; p < W*H; p++)
            send_pixel(p == 0, ((p / W) == 2 && (p % W) == 2), 0);
        drain();
        checks++;
        assert (first_win === 25'h0001000 && first_row === 3'd2 && first_col === 3'd2)
        else begin failures++; $error("FAIL impulse_first observed w=%h r=%0d c=%0d expected w=0001000 r=2 c=2", first_win, first_row, first_col); end
        checks++;
        assert (win_count == 16) else begin failures++; $error("FAIL impulse_count observed=%0d expected=16", win_count); end
        checks++;
        assert (eof_count == 1) else begin failures++; $error("FAIL impulse_eof observed=%0d expected=1", eof_count); end

        // Random frame, random m_ready and input gaps
        start_section();
        for (int p = 0; p < W*H; p++) begin
            if ($urandom_range(0, 3) == 0) do_cycle(1'b0, 1'b0, 1'b0, pick(1), acc);
            send_pixel(1'b0, 1'($urandom_range(0, 1)), 1);
        end
        drain();
        checks++;
        assert (win_count == 16) else begin failures++; $error("FAIL random_count observed=%0d expected=16", win_count); end

        // Column-parity frame
        start_section();
        for (int p = 0; p < W*H; p++)
            send_pixel(1'b0, 1'((p % W) % 2), 0);
        drain();
        checks++;
        assert (win_count == 16 && eof_count == 1)
        else begin failures++; $error("FAIL parity_count observed=%0d/%0d expected=16/1", win_count, eof_count); end

        // Start-of-frame on the 20th pixel
        start_section();
        for (int p = 0; p < 19; p++)
            send_pixel(1'b0, 1'($urandom_range(0, 1)), 0);
        sof_track = 1'b1;
        for (int p = 0; p < W*H; p++)
            send_pixel(p == 0, 1'($urandom_range(0, 1)), 0);
        drain();
        checks++;
        assert (win_count == 16 && first_row === 3'd2 && first_col === 3'd2)
        else begin failures++; $error("FAIL sof_frame observed n=%0d r=%0d c=%0d expected n=16 r=2 c=2", win_count, first_row, first_col); end

        // Asynchronous reset while a window is stalled
        start_section();
        for (int p = 0; p < 37; p++)
            send_pixel(1'b0, 1'($urandom_range(0, 1)), 2);
        checks++;
        assert (m_valid === 1'b1) else begin failures++; $error("FAIL stall_setup observed=%b expected=1", m_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        assert (m_valid === 1'b0 && m_window === 25'h0 && m_row === 3'd0 && m_col === 3'd0)
        else begin failures++; $error("FAIL async_reset observed v=%b w=%h r=%0d c=%0d expected all 0", m_valid, m_window, m_row, m_col); end
        exp_q.delete();
        mr = 0; mc = 0;
        stall_pending = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start_section();
        for (int p = 0; p < W*H; p++)
            send_pixel(1'b0, 1'($urandom_range(0, 1)), 1);
        drain();
        checks++;
        assert (win_count == 16 && eof_count == 1)
        else begin failures++; $error("FAIL post_reset_count observed=%0d/%0d expected=16/1", win_count, eof_count); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
